// File: rtl/weight_buffer_pkg.sv
// weight_buffer_pkg: controller FSM encoding, default widths and helpers.
// Shared by weight_buffer_ctrl and wb_addr_gen.
package weight_buffer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DRAIN,
    S_DONE
  } wb_state_e;

  localparam int WB_RD_WIDTH = 16;
  localparam int WB_WR_WIDTH = 64;
  localparam int RATIO       = WB_WR_WIDTH / WB_RD_WIDTH;
  localparam int RATIO_LOG2  = $clog2(RATIO);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wb_addr_gen.sv
// wb_addr_gen: read address and replay-pass counter for weight_buffer_ctrl.
// terminal flags the last address of the last pass.
import weight_buffer_pkg::*;

module wb_addr_gen #(
  parameter int AW = 7,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step,
  input  logic [AW-1:0] last_addr,
  input  logic [PW-1:0] last_pass,
  output logic [AW-1:0] addr,
  output logic          terminal
);

  logic [PW-1:0] pass;
  logic          wrap;

  assign wrap     = (addr == last_addr);
  assign terminal = wrap && (pass == last_pass);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr <= '0;
      pass <= '0;
    end else if (clear) begin
      addr <= '0;
      pass <= '0;
    end else if (step) begin
      if (wrap) begin
        addr <= '0;
        pass <= pass + PW'(1);
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl: loads a tile into weight_buffer, replays it to the PE array.
// Optional WB_CTRL_PERF_EN adds the stall_cycles counter output.
import weight_buffer_pkg::*;

module weight_buffer_ctrl #(
  parameter int RD_WIDTH      = WB_RD_WIDTH,
  parameter int WR_WIDTH      = WB_WR_WIDTH,
  parameter int RD_ADDR_WIDTH = 7,
  parameter int WR_ADDR_WIDTH = 5,
  parameter int REP_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [WR_ADDR_WIDTH:0]   cfg_wr_words,
  input  logic [REP_WIDTH-1:0]     cfg_repeat,
  input  logic                     s_valid,
  input  logic [WR_WIDTH-1:0]      s_data,
  output logic                     s_ready,
  input  logic                     pe_ready,
  output logic                     pe_valid,
  output logic [RD_WIDTH-1:0]      pe_data,
  output logic                     busy,
  output logic                     done,
  output logic                     write_req,
  output logic [WR_ADDR_WIDTH-1:0] write_addr,
  output logic [WR_WIDTH-1:0]      write_data,
  output logic                     read_req,
  output logic [RD_ADDR_WIDTH-1:0] read_addr,
  input  logic [RD_WIDTH-1:0]      read_data
`ifdef WB_CTRL_PERF_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int SHIFT = $clog2(WR_WIDTH / RD_WIDTH);
  localparam logic [WR_ADDR_WIDTH:0] MAX_WORDS = {1'b1, {WR_ADDR_WIDTH{1'b0}}};

  wb_state_e state, state_nx;

  logic                     accept;
  logic                     wr_fire;
  logic                     wr_last;
  logic                     terminal;
  logic [WR_ADDR_WIDTH-1:0] wr_cnt;
  logic [WR_ADDR_WIDTH-1:0] last_word;
  logic [WR_ADDR_WIDTH-1:0] last_word_q;
  logic [REP_WIDTH-1:0]     last_pass_q;
  logic [RD_ADDR_WIDTH-1:0] last_addr;

  assign accept  = start && (state == S_IDLE);
  assign wr_fire = s_valid && (state == S_LOAD);
  assign wr_last = (wr_cnt == last_word_q);

  // oversized tiles clamp to the full buffer
  assign last_word = (cfg_wr_words >= MAX_WORDS) ? '1 :
                     cfg_wr_words[WR_ADDR_WIDTH-1:0] - WR_ADDR_WIDTH'(1);

  assign last_addr  = {last_word_q, {SHIFT{1'b1}}};
  assign write_addr = wr_cnt;
  assign write_data = s_data;
  assign pe_data    = read_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_cnt      <= '0;
      last_word_q <= '0;
      last_pass_q <= '0;
      pe_valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      pe_valid <= read_req;
      if (accept) begin
        wr_cnt      <= '0;
        last_word_q <= last_word;
        last_pass_q <= (cfg_repeat == '0) ? '0 :
                       cfg_repeat - REP_WIDTH'(1);
      end else if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + WR_ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    write_req = 1'b0;
    read_req  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (cfg_wr_words == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        s_ready   = 1'b1;
        write_req = s_valid;
        busy      = 1'b1;
        if (wr_fire && wr_last)
          state_nx = S_READ;
      end
      S_READ: begin
        read_req = pe_ready;
        busy     = 1'b1;
        if (pe_ready && terminal)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  wb_addr_gen #(
    .AW(RD_ADDR_WIDTH),
    .PW(REP_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .step     (read_req),
    .last_addr(last_addr),
    .last_pass(last_pass_q),
    .addr     (read_addr),
    .terminal (terminal)
  );

`ifdef WB_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (accept)
      stall_cycles <= '0;
    else if ((state == S_LOAD && !s_valid) ||
             (state == S_READ && !pe_ready))
      stall_cycles <= sat_inc(stall_cycles);
  end
`endif

endmodule
